// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit producing a {hi, lo} result for the hi/lo registers.
// Signed operations work on magnitudes; signs are reapplied while the result is loaded.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     src_a,
   input  logic [WIDTH-1:0]     src_b,
   input  logic                 flush,
   output logic                 busy,
   output logic                 hl_write_enable,
   output logic [2*WIDTH-1:0]   hl_data
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               op_div_q, op_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
   logic [2*WIDTH-1:0] hl_data_q, hl_data_d;

   logic               is_signed, a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_fit;
   logic [WIDTH-1:0]   hi_step, lo_step;
   logic [WIDTH-1:0]   rem_fix, quo_fix;
   logic [2*WIDTH-1:0] prod, result;

   // Operand conversion and one iteration of shift-add / restoring divide
   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & src_a[WIDTH-1];
      b_neg     = is_signed & src_b[WIDTH-1];
      mag_a     = a_neg ? -src_a : src_a;
      mag_b     = b_neg ? -src_b : src_b;

      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_fit   = (div_shift >= {1'b0, opnd_q});
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;

      if (op_div_q) begin
         hi_step = div_fit ? div_diff : div_shift[WIDTH-1:0];
         lo_step = {acc_lo_q[WIDTH-2:0], div_fit};
      end else begin
         hi_step = mul_sum[WIDTH:1];
         lo_step = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end

      prod    = {hi_step, lo_step};
      rem_fix = neg_rem_q ? -hi_step : hi_step;
      quo_fix = neg_res_q ? -lo_step : lo_step;
      if (!op_div_q) begin
         result = neg_res_q ? -prod : prod;
      end else if (opnd_q == '0) begin
         result = {a_q, {WIDTH{1'b1}}};
      end else begin
         result = {rem_fix, quo_fix};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_div_d  = op_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      a_d       = a_q;
      opnd_d    = opnd_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      hl_data_d = hl_data_q;

      case (state_q)
         StIdle: begin
            if (start && !flush) begin
               state_d   = StCalc;
               cnt_d     = '0;
               op_div_d  = op[1];
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = op[1] & a_neg;
               a_d       = src_a;
               acc_hi_d  = '0;
               // Divide shifts the dividend through lo; multiply shifts the multiplier
               if (op[1]) begin
                  acc_lo_d = mag_a;
                  opnd_d   = mag_b;
               end else begin
                  acc_lo_d = mag_b;
                  opnd_d   = mag_a;
               end
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               acc_hi_d = hi_step;
               acc_lo_d = lo_step;
               cnt_d    = cnt_q + CntW'(1);
               if (cnt_q == LastIter) begin
                  state_d   = StDone;
                  hl_data_d = result;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         a_q       <= '0;
         opnd_q    <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         hl_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_div_q  <= op_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         a_q       <= a_d;
         opnd_q    <= opnd_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         hl_data_q <= hl_data_d;
      end
   end

   assign busy            = (state_q != StIdle);
   assign hl_write_enable = (state_q == StDone) & ~flush;
   assign hl_data         = hl_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, flush/reset sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        hl_write_enable;
   logic [63:0] hl_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] last_exp = 64'h0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .op              (op),
      .src_a           (src_a),
      .src_b           (src_b),
      .flush           (flush),
      .busy            (busy),
      .hl_write_enable (hl_write_enable),
      .hl_data         (hl_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          mid;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, sq, sr;
      logic [63:0] ua, ub, uq, ur, t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (o)
         2'b00: begin
            t = 64'(sa * sb);
            return t;
         end
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            sq = sa / sb;
            sr = sa % sb;
            uq = 64'(sq);
            ur = 64'(sr);
            return {ur[31:0], uq[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
   endtask

   // Samples 40 cycles after the start edge; index i is the cycle following edge k+i
   task automatic collect(input int mid_start, input logic [63:0] prev,
                          output logic [63:0] res, output int n_strobe, output int strobe_at,
                          output int n_busy, output bit held);
      res       = 'x;
      n_strobe  = 0;
      strobe_at = -1;
      n_busy    = 0;
      held      = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) n_busy++;
         if (hl_write_enable) begin
            n_strobe++;
            if (strobe_at < 0) strobe_at = i;
            res = hl_data;
         end
         if (i < 32 && hl_data !== prev) held = 1'b0;
         start = (i == mid_start);
      end
      start = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input int mid);
      logic [63:0] res;
      int          n_strobe, strobe_at, n_busy;
      bit          held;
      issue(o, a, b);
      collect(mid, last_exp, res, n_strobe, strobe_at, n_busy, held);
      check({name, " data"}, res, exp);
      check({name, " strobes"}, 64'(n_strobe), 64'd1);
      check({name, " strobe cycle"}, 64'(strobe_at), 64'd32);
      check({name, " busy cycles"}, 64'(n_busy), 64'd33);
      check({name, " hold in calc"}, 64'(held), 64'd1);
      last_exp = exp;
   endtask

   initial begin
      logic [63:0] res;
      int          n_strobe, strobe_at, n_busy, n_we;
      bit          held;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      vecs[0]  = '{"multu max",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1};
      vecs[1]  = '{"mult -3x7",      2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, -1};
      vecs[2]  = '{"div -7/2",       2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, -1};
      vecs[3]  = '{"divu 5/0",       2'b11, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 5};
      vecs[4]  = '{"div overflow",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1};
      vecs[5]  = '{"div -7/0",       2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, -1};
      vecs[6]  = '{"mult min*min",   2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1};
      vecs[7]  = '{"divu 100/7",     2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, -1};
      vecs[8]  = '{"div 7/-2",       2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, -1};
      vecs[9]  = '{"mult -1x1",      2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, -1};
      vecs[10] = '{"multu 0",        2'b01, 32'h0000_0000, 32'h1234_5678, 64'h0, -1};
      vecs[11] = '{"divu max/16",    2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, -1};

      rst   = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      src_a = 32'h0;
      src_b = 32'h0;
      @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset strobe", 64'(hl_write_enable), 64'd0);
      check("reset hl_data", hl_data, 64'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                                  vecs[i].mid);

      // Flush at the 10th CALC cycle, then an immediate restart
      issue(2'b11, 32'd100, 32'd7);
      n_we = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (hl_write_enable) n_we++;
      end
      @(negedge clk);
      if (hl_write_enable) n_we++;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush calc busy", 64'(busy), 64'd0);
      check("flush calc strobes", 64'(n_we), 64'd0);
      check("flush calc hl_data", hl_data, last_exp);
      run_check("divu after flush", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, -1);

      // Flush while in DONE suppresses the strobe only
      issue(2'b00, 32'hFFFF_FFFD, 32'h7);
      repeat (33) @(negedge clk);
      check("done strobe before flush", 64'(hl_write_enable), 64'd1);
      flush = 1'b1;
      #1;
      check("flush done strobe", 64'(hl_write_enable), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush done busy", 64'(busy), 64'd0);
      check("flush done hl_data", hl_data, 64'hFFFF_FFFF_FFFF_FFEB);
      last_exp = 64'hFFFF_FFFF_FFFF_FFEB;

      // Flush with start in IDLE drops the start
      @(negedge clk);
      op    = 2'b01;
      src_a = 32'd9;
      src_b = 32'd9;
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("flush idle busy", 64'(busy), 64'd0);
      collect(-1, last_exp, res, n_strobe, strobe_at, n_busy, held);
      check("flush idle strobes", 64'(n_strobe), 64'd0);

      // Asynchronous reset mid-CALC, release, and immediate start
      issue(2'b01, 32'h1234, 32'h5678);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async reset busy", 64'(busy), 64'd0);
      check("async reset strobe", 64'(hl_write_enable), 64'd0);
      check("async reset hl_data", hl_data, 64'h0);
      @(posedge clk);
      #1;
      check("held reset busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst   = 1'b1;
      op    = 2'b01;
      src_a = 32'd2;
      src_b = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      check("start after reset", 64'(busy), 64'd1);
      collect(-1, 64'h0, res, n_strobe, strobe_at, n_busy, held);
      check("multu 2x3 data", res, 64'h6);
      check("multu 2x3 strobes", 64'(n_strobe), 64'd1);
      check("multu 2x3 strobe cycle", 64'(strobe_at), 64'd32);
      last_exp = 64'h6;

      for (int n = 0; n < 40; n++) begin
         ro = 2'($urandom_range(0, 3));
         ra = rand_opnd();
         rb = rand_opnd();
         run_check($sformatf("random %0d op%0d %h %h", n, ro, ra, rb), ro, ra, rb,
                   ref_model(ro, ra, rb), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port src_a  input  32  multiplicand or dividend.
REQ-007 SHALL have port src_b  input  32  multiplier or divisor.
REQ-008 SHALL have port flush  input  1  synchronous abort from the pipeline.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight (state != IDLE).
REQ-010 SHALL have port hl_write_enable  output  1  one-cycle strobe; hl_data is valid; drives the register file's hi/lo write enable.
REQ-011 SHALL have port hl_data  output  64  result {hi, lo}; [63:32] goes to hi, [31:0] goes to lo.

Function
REQ-012 SHALL implement a three-state machine: IDLE, CALC, DONE.
REQ-013 IDLE with start=1 and flush=0 at edge k: SHALL latch op, src_a and src_b, clear the 5-bit iteration counter, and enter CALC.
REQ-014 CALC SHALL run exactly 32 iterations, one per edge (radix-2 shift-add multiply or restoring divide); after the 32nd, at edge k+32, SHALL enter DONE.
REQ-015 DONE SHALL last one cycle, then return to IDLE at edge k+33.
REQ-016 hl_write_enable SHALL equal (state==DONE) & ~flush.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 start while busy SHALL be ignored, with no queuing.
REQ-019 MULT SHALL produce the signed 64-bit product; MULTU SHALL produce the unsigned 64-bit product.
REQ-020 DIV and DIVU: lo SHALL be the quotient and hi the remainder.
REQ-021 Signed DIV SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; operands SHALL be converted to magnitudes and the results sign-corrected in DONE.
REQ-022 Divide by zero (either sign mode) SHALL take normal latency and give hi = latched src_a, lo = 32'hFFFF_FFFF.
REQ-023 Signed overflow 0x8000_0000 / 0xFFFF_FFFF SHALL give lo = 32'h8000_0000, hi = 0.
REQ-024 hl_data SHALL be registered, SHALL update only on entering DONE, and SHALL hold until the next DONE; it SHALL not change during CALC.
REQ-025 flush=1 in CALC SHALL return to IDLE at the next edge, with no strobe and hl_data unchanged.
REQ-026 flush=1 in IDLE together with start SHALL win; start is dropped.
REQ-027 flush=1 in DONE SHALL suppress hl_write_enable; the state still returns to IDLE; hl_data is already updated and is don't-care to consumers.
REQ-028 Operand inputs SHALL be don't-care after the start edge; only latched copies are used.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force state=IDLE, counter=0, all internal operand/accumulator registers=0, busy=0, hl_write_enable=0, hl_data=64'h0.
REQ-030 rst=0 mid-operation SHALL abandon the operation with no strobe, either during reset or after release.
REQ-031 After rst returns to 1, start SHALL be accepted at the first rising edge.

Verification
REQ-032 MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> hl_data=64'hFFFF_FFFE_0000_0001; strobe exactly one cycle, in the cycle after edge k+32; busy high for 33 cycles.
REQ-033 MULT 0xFFFF_FFFD (-3) x 7 -> hl_data=64'hFFFF_FFFF_FFFF_FFEB.
REQ-034 DIV 0xFFFF_FFF9 (-7) / 2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
REQ-035 DIVU 5 / 0 -> hi=5, lo=0xFFFF_FFFF; second start pulsed during CALC is ignored, with one strobe only.
REQ-036 DIVU 100 / 7 started, flush at 10th CALC cycle -> busy=0 next cycle, no strobe, hl_data keeps its previous value; a new start next cycle completes normally (lo=14, hi=2).
REQ-037 rst=0 driven between clock edges mid-CALC -> busy, hl_write_enable and hl_data read 0 before the next edge; release and start MULTU 2x3 -> hl_data=64'h6.
